// File: rtl/mult_div_unit.sv
// Multicycle HI/LO multiply/divide unit for the EX stage.
// Multiply finishes after MUL_CYCLES cycles; divide is a fixed 34-cycle restoring divider.
module mult_div_unit #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_control,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int DIV_CYCLES = 34;
    localparam int DIV_ITERS  = DIV_CYCLES - 2;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_PREP,
        S_DIV_ITER,
        S_DIV_FIX
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [5:0]  count;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_signed;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] divisor;
    logic        quo_neg;
    logic        rem_neg;
    logic        div_zero;

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] shifted;
    logic [32:0] diff;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (md_control == OP_MULT || md_control == OP_MULTU) begin
                        next_state = S_MUL;
                    end else if (md_control == OP_DIV || md_control == OP_DIVU) begin
                        next_state = S_DIV_PREP;
                    end
                end
            end
            S_MUL:      if (count == 6'd0) next_state = S_IDLE;
            S_DIV_PREP: next_state = S_DIV_ITER;
            S_DIV_ITER: if (count == 6'd0) next_state = S_DIV_FIX;
            S_DIV_FIX:  next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Two's-complement low 64 bits are identical for signed and unsigned once operands are extended.
    always_comb begin
        ext_a   = op_signed ? {{32{op_a[31]}}, op_a} : {32'b0, op_a};
        ext_b   = op_signed ? {{32{op_b[31]}}, op_b} : {32'b0, op_b};
        product = ext_a * ext_b;
        a_mag   = (op_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
        b_mag   = (op_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, divisor};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi        <= 32'd0;
            lo        <= 32'd0;
            done      <= 1'b0;
            count     <= 6'd0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            op_signed <= 1'b0;
            quo       <= 32'd0;
            rem       <= 32'd0;
            divisor   <= 32'd0;
            quo_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (md_control)
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            OP_MULT, OP_MULTU: begin
                                op_a      <= a;
                                op_b      <= b;
                                op_signed <= (md_control == OP_MULT);
                                count     <= 6'(MUL_CYCLES - 1);
                            end
                            OP_DIV, OP_DIVU: begin
                                op_a      <= a;
                                op_b      <= b;
                                op_signed <= (md_control == OP_DIV);
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (count == 6'd0) begin
                        hi   <= product[63:32];
                        lo   <= product[31:0];
                        done <= 1'b1;
                    end else begin
                        count <= count - 6'd1;
                    end
                end
                S_DIV_PREP: begin
                    quo      <= a_mag;
                    divisor  <= b_mag;
                    rem      <= 32'd0;
                    quo_neg  <= op_signed && (op_a[31] ^ op_b[31]);
                    rem_neg  <= op_signed && op_a[31];
                    div_zero <= (op_b == 32'd0);
                    count    <= 6'(DIV_ITERS - 1);
                end
                // A clear borrow bit means the divisor fits: keep the difference and shift in a 1.
                S_DIV_ITER: begin
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= shifted[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    if (count != 6'd0) begin
                        count <= count - 6'd1;
                    end
                end
                S_DIV_FIX: begin
                    if (div_zero) begin
                        lo <= 32'hFFFF_FFFF;
                        hi <= op_a;
                    end else begin
                        lo <= quo_neg ? (~quo + 32'd1) : quo;
                        hi <= rem_neg ? (~rem + 32'd1) : rem;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
